// File: rtl/decoder_scan.sv
// One-hot decoder with direct and dwell-timed scan modes.
// Define DECODER_SCAN_ONESHOT_EN to stop a scan after one full pass.
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**SEL_W-1:0] out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [OUT_W-1:0] ONE =
    {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_ONE =
    {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_ONE =
    {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   idx_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;
  logic               wrap_d;
  logic [OUT_W-1:0]   out_d;
  logic               vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx       <= '0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      wrap      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx       <= idx_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      wrap      <= wrap_d;
      out       <= out_d;
      out_valid <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    unique case (1'b1)
      !en: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
      en && in_valid: begin
        state_d = mode ? SCAN : DIRECT;
        idx_d   = sel;
        cnt_d   = '0;
        dwell_d = dwell;
      end
      en && !in_valid: begin
        unique case (state_q)
          SCAN: begin
            if (cnt_q == dwell_q) begin
              cnt_d = '0;
              idx_d = idx + SEL_ONE;
              if (&idx) begin
                wrap_d = 1'b1;
`ifdef DECODER_SCAN_ONESHOT_EN
                state_d = IDLE;
`endif
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Decode from next-state so out never lags idx.
    vld_d = (state_d != IDLE);
    out_d = vld_d ? (ONE << idx_d) : '0;
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Randomised and directed bench for decoder_scan.
// A cycle-count model predicts every output each clock.
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       in_valid;
  logic [2:0] sel;
  logic [3:0] dwell;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] idx;
  logic       wrap;

  decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .in_valid(in_valid),
    .sel(sel),
    .dwell(dwell),
    .out(out),
    .out_valid(out_valid),
    .idx(idx),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_st = 0;
  int m_sel = 0;
  int m_d = 0;
  int m_k = 0;
  logic [7:0] e_out;
  logic       e_vld;
  logic [2:0] e_idx;
  logic       e_wrap;

  task automatic lit(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  // Scan position is simply start + elapsed/(dwell+1).
  task automatic model_step();
    int step;
    int pos;
    logic [7:0] one;
    one = 8'd1;
    if (!rst_n || !en) m_st = 0;
    else if (in_valid) begin
      m_st  = mode ? 2 : 1;
      m_sel = int'(sel);
      m_d   = int'(dwell);
      m_k   = 0;
    end else if (m_st == 2) m_k++;
    e_out = '0; e_vld = 0; e_idx = '0; e_wrap = 0;
    if (m_st == 1) begin
      e_idx = 3'(m_sel);
      e_out = one << m_sel;
      e_vld = 1;
    end else if (m_st == 2) begin
      step = m_k / (m_d + 1);
      pos  = (m_sel + step) % 8;
      e_wrap = (step > 0) && (m_k % (m_d + 1) == 0)
               && (pos == 0);
`ifdef DECODER_SCAN_ONESHOT_EN
      if (step >= 8 - m_sel) m_st = 0;
      else begin
`else
      begin
`endif
        e_idx = 3'(pos);
        e_out = one << pos;
        e_vld = 1;
      end
    end
  endtask

  task automatic compare();
    checks++;
    if ({out, out_valid, idx, wrap} !==
        {e_out, e_vld, e_idx, e_wrap}) begin
      failures++;
      $display("FAIL model t=%0t act out=%h v=%b i=%0d w=%b exp out=%h v=%b i=%0d w=%b",
               $time, out, out_valid, idx, wrap,
               e_out, e_vld, e_idx, e_wrap);
    end
    checks++;
    if (out_valid ? !$onehot(out) : (out != 0)) begin
      failures++;
      $display("FAIL onehot act out=%h v=%b exp onehot/zero",
               out, out_valid);
    end
  endtask

  task automatic cyc(input logic e, input logic iv,
                     input logic md, input logic [2:0] s,
                     input logic [3:0] d);
    en = e; in_valid = iv; mode = md; sel = s; dwell = d;
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic zeros(input string nm);
    lit({nm, "_out"}, 32'(out), 0);
    lit({nm, "_vld"}, 32'(out_valid), 0);
    lit({nm, "_idx"}, 32'(idx), 0);
  endtask

  initial begin
    logic [7:0] one;
    int exp_idx [10];
    one = 8'd1;
    exp_idx = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};
    rst_n = 0; en = 0; mode = 0; in_valid = 0;
    sel = '0; dwell = '0;
    #2;
    zeros("reset");
    lit("reset_wrap", 32'(wrap), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 0, 0, 0);
    zeros("idle");

    cyc(1, 1, 0, 3'b101, 0);
    lit("direct_out", 32'(out), 32'h20);
    lit("direct_idx", 32'(idx), 5);
    lit("direct_vld", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, 0, 0);
      lit("direct_hold", 32'(out), 32'h20);
    end

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 3'b010, 0);
      zeros("gate");
    end
    for (int s = 0; s < 8; s++) begin
      cyc(1, 1, 0, 3'(s), 0);
      lit("sweep", 32'(out), 32'(one << s));
    end

    for (int i = 0; i < 10; i++) begin
      if (i == 0) cyc(1, 1, 1, 6, 2);
      else cyc(1, 0, 0, 0, 0);
`ifdef DECODER_SCAN_ONESHOT_EN
      if (i >= 6) zeros("dwell_end");
      else lit("dwell_idx", 32'(idx), 32'(exp_idx[i]));
`else
      lit("dwell_idx", 32'(idx), 32'(exp_idx[i]));
`endif
      lit("dwell_wrap", 32'(wrap), 32'(i == 6));
    end

    for (int i = 0; i < 17; i++) begin
      if (i == 0) cyc(1, 1, 1, 0, 0);
      else cyc(1, 0, 0, 0, 0);
`ifdef DECODER_SCAN_ONESHOT_EN
      if (i >= 8) lit("fast_out", 32'(out), 0);
      else lit("fast_out", 32'(out), 32'(one << i));
      lit("fast_wrap", 32'(wrap), 32'(i == 8));
`else
      lit("fast_out", 32'(out), 32'(one << (i % 8)));
      lit("fast_wrap", 32'(wrap),
          32'((i % 8 == 0) && (i > 0)));
`endif
    end

    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    lit("pre_idx", 32'(idx), 3);
    cyc(1, 1, 0, 1, 0);
    lit("pre_out", 32'(out), 32'h02);
    cyc(1, 0, 0, 0, 0);
    lit("pre_hold", 32'(out), 32'h02);

    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    lit("rst_idx4", 32'(idx), 4);
    #2 rst_n = 0;
    #1;
    zeros("rst_mid");
    cyc(1, 0, 0, 0, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    zeros("rst_after");

    for (int i = 0; i < 600; i++) begin
      logic e, iv, md;
      logic [3:0] d;
      e  = ($urandom_range(0, 15) != 0);
      iv = ($urandom_range(0, 9) == 0);
      md = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 7) == 0) ? 4'd15
           : 4'($urandom_range(0, 3));
      cyc(e, iv, md, 3'($urandom_range(0, 7)), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
